csa_sum_pipe: RTL and testbench
===============================

Name: csa_sum_pipe

Overview:
- Pipelined multi-operand adder built from cascaded 4:2 carry-save reduction levels, with a registered final carry-propagate adder.
- Sums OPS operands of N bits plus a carry-in at one beat per cycle.
- Optional accumulate mode sums a group of beats into a running total.
- Sits in the datapath as the shared reduction engine for the multiplier and multi-operand ALU paths.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- N, 32, operand width in bits.
- OPS, 8, operand count; power of two, at least 4.
- ACC_EXT, 8, extra accumulator guard bits.
- Derived: LEVELS = log2(OPS)-1 reduction levels.
- Derived: W = N + log2(OPS) + ACC_EXT, the result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_ops  in  OPS*N  packed operands; operand k is in_ops[k*N +: N].
- in_cin  in  1  carry-in added at bit 0.
- in_acc  in  1  beat belongs to an accumulation group.
- in_last  in  1  final beat of the group; ignored when in_acc=0.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W  result.
- out_ovf  out  1  accumulation wrapped past W bits; valid with out_sum.

Behaviour:
- Reset (async, active-high):
  - All stage valid bits, out_valid, out_sum, out_ovf, the accumulator and the sticky overflow clear to 0 immediately.
  - The pipeline resumes on the first edge after rst deasserts.
- Reduction structure:
  - Each level halves the vector count with 4:2 reducers: OPS -> OPS/2 -> ... -> 2 (sum, carry).
  - in_cin enters as the carry-in of the first level.
  - Each level output is registered together with the acc/last/valid tag.
  - Vectors are zero-extended to W bits.
- Final stage (registered), T = S + C:
  - in_acc=0 (standalone): out_sum = T, out_ovf = 0, accumulator untouched.
  - in_acc=1, not last: acc <= acc + T (mod 2^W); sticky ovf |= carry-out of bit W-1. No output is produced.
  - in_acc=1, last: out_sum = acc + T (mod 2^W); out_ovf = sticky | carry-out; acc and sticky then clear to 0.
- Latency and throughput:
  - A beat accepted at edge k produces out_valid after edge k+LEVELS+1 (3 cycles for OPS=8).
  - Throughput is one beat per cycle.
- Stall rule:
  - en = !(out_valid && !out_ready); in_ready = en.
  - When en=0, every stage register, the accumulator and the sticky bit hold.
  - out_sum and out_ovf stay stable while out_valid=1 and out_ready=0.
  - Bubbles (invalid stages) advance whenever en=1.
  - The accumulator updates only when a valid beat advances out of the final stage with en=1.
- Output register:
  - When en=1 and the final stage produces no output, out_valid <= 0.
- Interleaving:
  - A standalone beat may sit between beats of an open group; it does not disturb acc.
- Sequencing:
  - One group is open at a time. A new group starts implicitly after a last beat.
- No combinational path from in_valid to out_valid.
- The in_ready path from out_ready is combinational by design.

Test Plan:
1. N=32, OPS=8: all eight ops = 0xFFFFFFFF, cin=1, acc=0 -> out_sum = 0x7FFFFFFF9 exactly 3 cycles after acceptance; out_ovf = 0.
2. Accumulate: three beats, all ops = 1, cin=0, acc=1, last on the third -> one result out_sum = 24, out_ovf = 0; a following standalone beat of all ops = 2 -> 16.
3. Overflow: 257 beats of all ops = 0xFFFFFFFF, acc=1, last on the 257th -> out_sum = 0x7FFFFF7F8, out_ovf = 1; the next group starts from 0 with ovf cleared.
4. Stall:
   - Stimulus: continuous valid beats with values 1..10 (all ops = i); hold out_ready=0 for 5 cycles after the first out_valid.
   - Required: in_ready = 0 during the stall; out_sum = 8 stays stable; all ten results 8*i appear in order; no beat lost or duplicated.
5. Reset mid-group: two acc beats, then pulse rst asynchronously between edges.
   - Required: out_valid drops at once and nothing is emitted.
   - Then a group of one beat (all ops = 3, last) -> out_sum = 24.
6. Randomised back-to-back mix of standalone and grouped beats, cin random, out_ready random.
   - Required: every result equals the reference sum of operands + cin (plus the group total where grouped), and results appear in order.

Source files
------------

// File: rtl/csa_sum_pipe_if.sv
// Handshake bundle for csa_sum_pipe: operand beats in, summed results out.
// The master drives beats and accepts results; the slave is the adder.
interface csa_sum_pipe_if #(
  parameter int N       = 32,
  parameter int OPS     = 8,
  parameter int ACC_EXT = 8
);
  localparam int W = N + $clog2(OPS) + ACC_EXT;

  logic             in_valid;
  logic             in_ready;
  logic [OPS*N-1:0] in_ops;
  logic             in_cin;
  logic             in_acc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_ops, in_cin, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_ops, in_cin, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/csa_sum_pipe.sv
// Pipelined multi-operand adder. Operands are registered, reduced by cascaded
// 4:2 carry-save levels (one register per level), then resolved by a
// registered carry-propagate add that either emits the sum directly or folds
// it into a running group total. A single enable stalls the whole pipe when
// the output holds a result the consumer has not taken.
module csa_sum_pipe #(
  parameter int N       = 32,
  parameter int OPS     = 8,
  parameter int ACC_EXT = 8
) (
  input logic             clk,
  input logic             rst,
  csa_sum_pipe_if.slave   bus
);
  localparam int LOG2OPS = $clog2(OPS);
  localparam int LEVELS  = LOG2OPS - 1;
  localparam int W       = N + LOG2OPS + ACC_EXT;

  logic            en;
  logic [LEVELS:0] stgVld;
  logic [LEVELS:0] stgAcc;
  logic [LEVELS:0] stgLast;
  logic            stgCin;

  logic            outValid;
  logic [W-1:0]    outSum;
  logic            outOvf;
  logic [W-1:0]    accReg;
  logic            ovfSticky;
  logic [W-1:0]    tSum;
  logic [W:0]      accSum;

  // The only back-pressure point is an untaken result; everything moves together.
  assign en           = !(outValid && !bus.out_ready);
  assign bus.in_ready = en;

  assign bus.out_valid = outValid;
  assign bus.out_sum   = outSum;
  assign bus.out_ovf   = outOvf;

  // Tag pipeline: valid/acc/last travel alongside the data of each level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stgVld  <= '0;
      stgAcc  <= '0;
      stgLast <= '0;
      stgCin  <= 1'b0;
    end else if (en) begin
      stgVld  <= {stgVld[LEVELS-1:0],  bus.in_valid};
      stgAcc  <= {stgAcc[LEVELS-1:0],  bus.in_acc};
      stgLast <= {stgLast[LEVELS-1:0], bus.in_last};
      stgCin  <= bus.in_cin;
    end
  end

  // Level 0 holds the raw operands; level l holds OPS>>l partial vectors,
  // ending at the sum/carry pair of level LEVELS.
  for (genvar l = 0; l <= LEVELS; l++) begin : gLvl
    localparam int CNT = OPS >> l;
    logic [W-1:0] vec [CNT];

    if (l == 0) begin : gIn
      // Capture the operand beat, zero-extended to the result width.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < CNT; j++) vec[j] <= '0;
        end else if (en) begin
          for (int j = 0; j < CNT; j++)
            vec[j] <= {{(W-N){1'b0}}, bus.in_ops[j*N +: N]};
        end
      end
    end else begin : gRedLvl
      logic [W-1:0] red [CNT];

      // Each 4:2 reducer is two chained carry-save rows; the beat carry-in
      // rides in the free bit 0 of the very first shifted carry.
      for (genvar r = 0; r < CNT/2; r++) begin : gRed
        logic [W-1:0] a, b, c, d, t, u;
        logic         cinBit;

        if (l == 1 && r == 0) begin : gCin
          assign cinBit = stgCin;
        end else begin : gNoCin
          assign cinBit = 1'b0;
        end

        assign a = gLvl[l-1].vec[4*r];
        assign b = gLvl[l-1].vec[4*r+1];
        assign c = gLvl[l-1].vec[4*r+2];
        assign d = gLvl[l-1].vec[4*r+3];
        assign t = a ^ b ^ c;
        assign u = (((a & b) | (a & c) | (b & c)) << 1) | {{(W-1){1'b0}}, cinBit};
        assign red[2*r]   = t ^ d ^ u;
        assign red[2*r+1] = ((t & d) | (t & u) | (d & u)) << 1;
      end

      // Register this level's reduced vectors.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < CNT; j++) vec[j] <= '0;
        end else if (en) begin
          for (int j = 0; j < CNT; j++) vec[j] <= red[j];
        end
      end
    end
  end

  assign tSum   = gLvl[LEVELS].vec[0] + gLvl[LEVELS].vec[1];
  assign accSum = {1'b0, accReg} + {1'b0, tSum};

  // Final stage: emit standalone sums, fold group beats into the total, and
  // close a group on its last beat by emitting and clearing the total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid  <= 1'b0;
      outSum    <= '0;
      outOvf    <= 1'b0;
      accReg    <= '0;
      ovfSticky <= 1'b0;
    end else if (en) begin
      outValid <= 1'b0;
      if (stgVld[LEVELS]) begin
        if (!stgAcc[LEVELS]) begin
          outValid <= 1'b1;
          outSum   <= tSum;
          outOvf   <= 1'b0;
        end else if (stgLast[LEVELS]) begin
          outValid  <= 1'b1;
          outSum    <= accSum[W-1:0];
          outOvf    <= ovfSticky | accSum[W];
          accReg    <= '0;
          ovfSticky <= 1'b0;
        end else begin
          accReg    <= accSum[W-1:0];
          ovfSticky <= ovfSticky | accSum[W];
        end
      end
    end
  end
endmodule

// File: tb/tb_csa_sum_pipe.sv
// Directed bench for csa_sum_pipe: latency, grouping, overflow, stall,
// asynchronous reset and a randomised mix checked against a reference sum.
module tb_csa_sum_pipe;
  localparam int N       = 32;
  localparam int OPS     = 8;
  localparam int ACC_EXT = 8;
  localparam int W       = N + $clog2(OPS) + ACC_EXT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csa_sum_pipe_if #(.N(N), .OPS(OPS), .ACC_EXT(ACC_EXT)) bus ();
  csa_sum_pipe #(.N(N), .OPS(OPS), .ACC_EXT(ACC_EXT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cmpCnt = 0;
  int errCnt = 0;
  logic [W:0] gotQ [$];
  logic [W:0] expQ [$];
  logic done;

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      gotQ.push_back({bus.out_ovf, bus.out_sum});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OPS*N-1:0] allOps(input logic [N-1:0] v);
    logic [OPS*N-1:0] r;
    for (int k = 0; k < OPS; k++) r[k*N +: N] = v;
    return r;
  endfunction

  task automatic sendBeat(input logic [OPS*N-1:0] ops, input logic cin, input logic acc,
                          input logic last);
    logic rdy;
    int   guard;
    bus.in_valid = 1'b1;
    bus.in_ops   = ops;
    bus.in_cin   = cin;
    bus.in_acc   = acc;
    bus.in_last  = last;
    rdy   = 1'b0;
    guard = 0;
    while (!rdy && guard < 1000) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!rdy) chk("acceptTimeout", 64'(rdy), 64'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_acc   = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_cin   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (gotQ.size() < expQ.size() && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk({tag, ".count"}, 64'(gotQ.size()), 64'(expQ.size()));
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      chk({tag, ".sum"}, 64'(gotQ[0][W-1:0]), 64'(expQ[0][W-1:0]));
      chk({tag, ".ovf"}, 64'(gotQ[0][W]), 64'(expQ[0][W]));
      void'(gotQ.pop_front());
      void'(expQ.pop_front());
    end
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    logic [OPS*N-1:0] rOps;
    logic             rCin, rAcc, rLast;
    logic [63:0]      tRef, sRef, mAcc;
    logic             mOvf;
    int               g;

    bus.in_valid  = 1'b0;
    bus.in_ops    = '0;
    bus.in_cin    = 1'b0;
    bus.in_acc    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    done          = 1'b0;

    #1 rst = 1'b1;
    #10;
    chk("rst.outValid", 64'(bus.out_valid), 64'd0);
    chk("rst.outSum",   64'(bus.out_sum),   64'd0);
    chk("rst.outOvf",   64'(bus.out_ovf),   64'd0);
    chk("rst.inReady",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: all-ones operands with carry-in, exact three-cycle latency
    sendBeat(allOps(32'hFFFF_FFFF), 1'b1, 1'b0, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("t1.validAfter1", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1.validAfter2", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1.validAfter3", 64'(bus.out_valid), 64'd1);
    chk("t1.sum", 64'(bus.out_sum), 64'h7_FFFF_FFF9);
    chk("t1.ovf", 64'(bus.out_ovf), 64'd0);
    expQ.push_back({1'b0, 43'h7_FFFF_FFF9});
    drain("t1");

    // 2: three-beat group then a standalone beat
    sendBeat(allOps(32'd1), 1'b0, 1'b1, 1'b0);
    sendBeat(allOps(32'd1), 1'b0, 1'b1, 1'b0);
    sendBeat(allOps(32'd1), 1'b0, 1'b1, 1'b1);
    sendBeat(allOps(32'd2), 1'b0, 1'b0, 1'b0);
    idle();
    expQ.push_back({1'b0, 43'd24});
    expQ.push_back({1'b0, 43'd16});
    drain("t2");

    // 3: 257-beat group wraps the total; next group starts clean
    for (int i = 0; i < 257; i++)
      sendBeat(allOps(32'hFFFF_FFFF), 1'b0, 1'b1, i == 256);
    sendBeat(allOps(32'd1), 1'b0, 1'b1, 1'b1);
    idle();
    expQ.push_back({1'b1, 43'h7_FFFF_F7F8});
    expQ.push_back({1'b0, 43'd8});
    drain("t3");

    // 4: back-to-back beats with a five-cycle output stall
    for (int i = 1; i <= 10; i++) expQ.push_back((W+1)'(8 * i));
    fork
      begin
        for (int i = 1; i <= 10; i++) sendBeat(allOps(N'(i)), 1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        g = 0;
        while (!bus.out_valid && g < 50) begin
          @(posedge clk); #1;
          g++;
        end
        chk("t4.sawValid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(posedge clk); #1;
          chk("t4.stallInReady",  64'(bus.in_ready),  64'd0);
          chk("t4.stallOutValid", 64'(bus.out_valid), 64'd1);
          chk("t4.stallSum",      64'(bus.out_sum),   64'd8);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("t4");

    // 5: asynchronous reset drops a held result and the open group
    bus.out_ready = 1'b0;
    sendBeat(allOps(32'd2), 1'b0, 1'b1, 1'b0);
    sendBeat(allOps(32'd2), 1'b0, 1'b1, 1'b0);
    sendBeat(allOps(32'd5), 1'b0, 1'b0, 1'b0);
    idle();
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("t5.heldValid", 64'(bus.out_valid), 64'd1);
    chk("t5.heldSum",   64'(bus.out_sum),   64'd40);
    #2 rst = 1'b1;
    #1;
    chk("t5.rstValid",   64'(bus.out_valid), 64'd0);
    chk("t5.rstSum",     64'(bus.out_sum),   64'd0);
    chk("t5.rstInReady", 64'(bus.in_ready),  64'd1);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    gotQ.delete();
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("t5.noEmit", 64'(gotQ.size()), 64'd0);
    sendBeat(allOps(32'd3), 1'b0, 1'b1, 1'b1);
    idle();
    expQ.push_back({1'b0, 43'd24});
    drain("t5");

    // 6: random mix with random consumer back-pressure
    mAcc = '0;
    mOvf = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 60; b++) begin
          for (int k = 0; k < OPS; k++) rOps[k*N +: N] = $urandom();
          rCin  = 1'($urandom_range(0, 1));
          rAcc  = 1'($urandom_range(0, 1));
          rLast = ($urandom_range(0, 2) == 0);
          if (b == 59) begin
            rAcc  = 1'b1;
            rLast = 1'b1;
          end
          tRef = 64'(rCin);
          for (int k = 0; k < OPS; k++) tRef = tRef + 64'(rOps[k*N +: N]);
          if (!rAcc) begin
            expQ.push_back({1'b0, tRef[W-1:0]});
          end else begin
            sRef = 64'(mAcc[W-1:0]) + tRef;
            if (rLast) begin
              expQ.push_back({mOvf | sRef[W], sRef[W-1:0]});
              mAcc = '0;
              mOvf = 1'b0;
            end else begin
              mAcc = 64'(sRef[W-1:0]);
              mOvf = mOvf | sRef[W];
            end
          end
          sendBeat(rOps, rCin, rAcc, rLast);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end
endmodule
